// File: rtl/alu_req_arbiter.sv
// ---------------------------------------------------------------------------
// alu_req_arbiter
//
// Shares one external combinational ALU between two requesters.
// A round-robin arbiter picks one pending op, the winning operands are
// registered onto alu_a/alu_b/alu_sel, the ALU output is captured after a
// settle window of EXEC_CYCLES cycles, and the result is returned on a single
// valid/ready response channel tagged with the owning requester.
//
// Parameters
//   WIDTH        operand/result width (must match the ALU instance)
//   EXEC_CYCLES  cycles operands are held on the ALU before capture (>= 1)
//
// Ports
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   r0_valid/r0_ready         requester 0 handshake (ready only asserted in IDLE)
//   r0_a, r0_b, r0_sel        requester 0 operands and opcode
//   r1_*                      same for requester 1
//   alu_a, alu_b, alu_sel     registered operands/opcode driven to the ALU
//   alu_out                   ALU result
//   rsp_valid/rsp_ready       response handshake
//   rsp_id                    requester owning the response
//   rsp_data                  captured ALU result
//   rsp_err                   opcode was outside the defined set (1010..1111)
//
// Configuration
//   ALU_FLAGS_EN  when defined, adds rsp_zero (rsp_data == 0) and rsp_neg
//                 (rsp_data MSB), registered alongside rsp_data.
// ---------------------------------------------------------------------------
module alu_req_arbiter #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [WIDTH-1:0] r0_a,
    input  logic [WIDTH-1:0] r0_b,
    input  logic [3:0]       r0_sel,

    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [WIDTH-1:0] r1_a,
    input  logic [WIDTH-1:0] r1_b,
    input  logic [3:0]       r1_sel,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_out,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err
`ifdef ALU_FLAGS_EN
    ,
    output logic             rsp_zero,
    output logic             rsp_neg
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam int unsigned CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

    // Opcodes above this value are undefined for the ALU.
    localparam logic [3:0] SEL_MAX = 4'b1001;

    logic [1:0]       r_state;
    logic             r_prio;       // 0: r0 wins a tie, 1: r1 wins a tie
    logic [CNT_W-1:0] r_cnt;
    logic             r_id;         // owner of the op currently on the ALU

    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [3:0]       r_alu_sel;

    logic             r_rsp_valid;
    logic             r_rsp_id;
    logic [WIDTH-1:0] r_rsp_data;
    logic             r_rsp_err;

    logic             w_idle;
    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_accept;
    logic             w_rsp_done;

    // -----------------------------------------------------------------------
    // Arbitration: grant only in IDLE. A lone requester always wins; on a
    // tie the priority holder wins.
    // -----------------------------------------------------------------------
    assign w_idle     = (r_state == IDLE);
    assign w_gnt0     = w_idle & r0_valid & (~r1_valid | ~r_prio);
    assign w_gnt1     = w_idle & r1_valid & (~r0_valid |  r_prio);
    assign w_accept   = w_gnt0 | w_gnt1;
    assign w_rsp_done = (r_state == RESP) & r_rsp_valid & rsp_ready;

    assign r0_ready = w_gnt0;
    assign r1_ready = w_gnt1;

    // -----------------------------------------------------------------------
    // Control FSM, priority and settle counter
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_prio  <= 1'b0;
            r_cnt   <= '0;
            r_id    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_id    <= w_gnt1;
                        r_cnt   <= CNT_W'(EXEC_CYCLES - 1);
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    if (r_cnt == '0) begin
                        r_state <= RESP;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    // The requester just served yields the tie-break.
                    if (w_rsp_done) begin
                        r_prio  <= ~r_rsp_id;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Operand issue: latched on the request handshake, held afterwards so the
    // ALU inputs keep the last issued op.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_sel <= '0;
        end else if (w_accept) begin
            r_alu_a   <= w_gnt1 ? r1_a   : r0_a;
            r_alu_b   <= w_gnt1 ? r1_b   : r0_b;
            r_alu_sel <= w_gnt1 ? r1_sel : r0_sel;
        end
    end

    assign alu_a   = r_alu_a;
    assign alu_b   = r_alu_b;
    assign alu_sel = r_alu_sel;

    // -----------------------------------------------------------------------
    // Response capture and hold
    // -----------------------------------------------------------------------
    logic w_capture;
    assign w_capture = (r_state == EXEC) & (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
        end else if (w_capture) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_id;
            r_rsp_data  <= alu_out;
            r_rsp_err   <= (r_alu_sel > SEL_MAX);
        end else if (w_rsp_done) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;

`ifdef ALU_FLAGS_EN
    logic r_rsp_zero;
    logic r_rsp_neg;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_zero <= 1'b0;
            r_rsp_neg  <= 1'b0;
        end else if (w_capture) begin
            r_rsp_zero <= (alu_out == '0);
            r_rsp_neg  <= alu_out[WIDTH-1];
        end
    end

    assign rsp_zero = r_rsp_zero;
    assign rsp_neg  = r_rsp_neg;
`endif

endmodule

// File: tb/tb_alu_req_arbiter.sv
module tb_alu_req_arbiter;

    localparam int W    = 16;
    localparam int EXEC = 2;

    logic          clk;
    logic          rst;
    logic          r0_valid, r0_ready, r1_valid, r1_ready;
    logic [W-1:0]  r0_a, r0_b, r1_a, r1_b;
    logic [3:0]    r0_sel, r1_sel;
    logic [W-1:0]  alu_a, alu_b, alu_out;
    logic [3:0]    alu_sel;
    logic          rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [W-1:0]  rsp_data;
`ifdef ALU_FLAGS_EN
    logic          rsp_zero, rsp_neg;
`endif

    int total = 0;
    int bad   = 0;
    int m_prio = 0;   // reference tie-break owner

    alu_req_arbiter #(.WIDTH(W), .EXEC_CYCLES(EXEC)) dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_sel(r0_sel),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_sel(r1_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err)
`ifdef ALU_FLAGS_EN
        , .rsp_zero(rsp_zero), .rsp_neg(rsp_neg)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [3:0] sel);
        case (sel)
            4'd0, 4'd8: return a + b;
            4'd1, 4'd9: return a - b;
            4'd2:       return ~a;
            4'd3:       return ~b;
            4'd4:       return a & b;
            4'd5:       return a | b;
            4'd6:       return a ^ b;
            4'd7:       return ~(a ^ b);
            default:    return '0;
        endcase
    endfunction

    // Environment ALU shared by the arbiter.
    always_comb alu_out = alu_fn(alu_a, alu_b, alu_sel);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_prio = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_alu_a"},   32'(alu_a),     0);
        chk({tag, "_alu_b"},   32'(alu_b),     0);
        chk({tag, "_alu_sel"}, 32'(alu_sel),   0);
        chk({tag, "_rvalid"},  32'(rsp_valid), 0);
        chk({tag, "_rid"},     32'(rsp_id),    0);
        chk({tag, "_rdata"},   32'(rsp_data),  0);
        chk({tag, "_rerr"},    32'(rsp_err),   0);
`ifdef ALU_FLAGS_EN
        chk({tag, "_rzero"},   32'(rsp_zero),  0);
        chk({tag, "_rneg"},    32'(rsp_neg),   0);
`endif
    endtask

    // One complete transaction. Entered #1 after a rising edge with the DUT
    // idle; returns #1 after the response handshake edge.
    task automatic op(input logic v0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                      input logic [3:0] s0,
                      input logic v1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                      input logic [3:0] s1,
                      input int stall,
                      output logic [W-1:0] got_data, output logic got_id);
        int win, n;
        logic [W-1:0] ea, eb, ed;
        logic [3:0] es;
        win = (v0 && v1) ? m_prio : (v1 ? 1 : 0);
        ea = win ? a1 : a0;
        eb = win ? b1 : b0;
        es = win ? s1 : s0;
        ed = alu_fn(ea, eb, es);

        r0_valid = v0; r0_a = a0; r0_b = b0; r0_sel = s0;
        r1_valid = v1; r1_a = a1; r1_b = b1; r1_sel = s1;
        #3;
        chk("r0_ready", 32'(r0_ready), 32'(win == 0));
        chk("r1_ready", 32'(r1_ready), 32'(win == 1));
        @(posedge clk); #1;
        // Scramble inputs: the issued op must already be latched.
        r0_valid = 1'b0; r1_valid = 1'b0;
        r0_a = W'($urandom); r0_b = W'($urandom); r0_sel = 4'($urandom);
        r1_a = W'($urandom); r1_b = W'($urandom); r1_sel = 4'($urandom);
        chk("alu_a",   32'(alu_a),   32'(ea));
        chk("alu_b",   32'(alu_b),   32'(eb));
        chk("alu_sel", 32'(alu_sel), 32'(es));

        n = 0;
        while (rsp_valid !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency",  32'(n),        32'(EXEC));
        chk("rsp_id",   32'(rsp_id),   32'(win));
        chk("rsp_data", 32'(rsp_data), 32'(ed));
        chk("rsp_err",  32'(rsp_err),  32'(es > 4'd9));
`ifdef ALU_FLAGS_EN
        chk("rsp_zero", 32'(rsp_zero), 32'(ed == '0));
        chk("rsp_neg",  32'(rsp_neg),  32'(ed[W-1]));
`endif
        got_data = rsp_data;
        got_id   = rsp_id;

        for (int i = 0; i < stall; i++) begin
            r0_valid = 1'b1; r1_valid = 1'b1;
            #3;
            chk("stall_r0_ready", 32'(r0_ready), 0);
            chk("stall_r1_ready", 32'(r1_ready), 0);
            @(posedge clk); #1;
            chk("stall_valid", 32'(rsp_valid), 1);
            chk("stall_data",  32'(rsp_data),  32'(ed));
            chk("stall_id",    32'(rsp_id),    32'(win));
        end
        r0_valid = 1'b0; r1_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("rsp_drop",   32'(rsp_valid), 0);
        chk("alu_a_kept", 32'(alu_a),     32'(ea));
        m_prio = 1 - win;
    endtask

    initial begin
        logic [W-1:0] d;
        logic id;
        rst = 1'b1; rsp_ready = 1'b0;
        r0_valid = 1'b0; r0_a = '0; r0_b = '0; r0_sel = '0;
        r1_valid = 1'b0; r1_a = '0; r1_b = '0; r1_sel = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        m_prio = 0;
        chk_all_zero("reset");
        chk("reset_r0_ready", 32'(r0_ready), 0);
        chk("reset_r1_ready", 32'(r1_ready), 0);

        // Basic add from r0.
        op(1'b1, 16'h0005, 16'h0003, 4'b0000, 1'b0, '0, '0, '0, 0, d, id);
        chk("add_data", 32'(d), 32'h0008);
        chk("add_id",   32'(id), 0);

        // Ties after reset: r0 first, then alternation.
        do_reset();
        op(1'b1, 16'h0009, 16'h0004, 4'b0001, 1'b1, 16'hF0F0, 16'h0FF0, 4'b0110, 0, d, id);
        chk("tie1_id", 32'(id), 0);
        chk("tie1_data", 32'(d), 32'h0005);
        op(1'b1, 16'h0009, 16'h0004, 4'b0001, 1'b1, 16'hF0F0, 16'h0FF0, 4'b0110, 0, d, id);
        chk("tie2_id", 32'(id), 1);
        chk("tie2_data", 32'(d), 32'hFF00);
        op(1'b1, 16'h1111, 16'h2222, 4'b0101, 1'b1, 16'h3333, 16'h0F0F, 4'b0100, 0, d, id);
        chk("tie3_id", 32'(id), 0);
        op(1'b1, 16'h1111, 16'h2222, 4'b0101, 1'b1, 16'h3333, 16'h0F0F, 4'b0100, 0, d, id);
        chk("tie4_id", 32'(id), 1);

        // Subtract wrap-around.
        op(1'b0, '0, '0, '0, 1'b1, 16'h0000, 16'h0001, 4'b0001, 0, d, id);
        chk("wrap_data", 32'(d), 32'hFFFF);

        // Long consumer stall.
        op(1'b1, 16'hABCD, 16'h1234, 4'b0110, 1'b0, '0, '0, '0, 5, d, id);
        chk("stall_result", 32'(d), 32'hB9F9);

        // Undefined opcode, then the duplicate add encoding.
        op(1'b1, 16'h7777, 16'h1111, 4'b1100, 1'b0, '0, '0, '0, 0, d, id);
        chk("err_data", 32'(d), 32'h0000);
        chk("err_flag", 32'(rsp_err), 1);
        op(1'b1, 16'h0007, 16'h0009, 4'b1000, 1'b0, '0, '0, '0, 0, d, id);
        chk("add8_data", 32'(d), 32'h0010);
        chk("add8_err", 32'(rsp_err), 0);

        // Reset during EXEC: priority currently favours r1.
        r1_valid = 1'b1; r1_a = 16'h4444; r1_b = 16'h1111; r1_sel = 4'b0000;
        @(posedge clk); #1;
        r1_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_prio = 0;
        chk_all_zero("midrst");
        for (int i = 0; i < EXEC + 3; i++) begin
            @(posedge clk); #1;
            chk("midrst_no_rsp", 32'(rsp_valid), 0);
        end
        op(1'b1, 16'h0001, 16'h0001, 4'b0000, 1'b1, 16'h0002, 16'h0002, 4'b0000, 0, d, id);
        chk("midrst_tie_id", 32'(id), 0);

        // Randomised traffic.
        for (int k = 0; k < 40; k++) begin
            logic v0, v1;
            v0 = 1'($urandom);
            v1 = 1'($urandom);
            if (!v0 && !v1) v0 = 1'b1;
            op(v0, W'($urandom), W'($urandom), 4'($urandom),
               v1, W'($urandom), W'($urandom), 4'($urandom),
               int'($urandom_range(0, 3)), d, id);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
